sonar_echo_detector: RTL and testbench

Parametrised, multi-channel successor to the single-channel sonar receive chain: gain, magnitude, moving-average and threshold detection. Processes `N_CH` PCM channels in parallel with a programmable moving-average depth and a hysteresis comparator. Adds a ping/time-of-flight state machine that timestamps the first echo after a transmit start. Sits between the PCM front end (sample strobe `ce`) and the Wishbone/LA register space.

---
 rtl/sonar_echo_detector.sv | 156 +++++++++++++++
 tb/tb_sonar_echo_detector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_detector.sv
// Multi-channel sonar receive chain: gain, magnitude, moving average and
// hysteresis detection per channel, plus a ping/time-of-flight FSM.
module sonar_echo_detector #(
  parameter  int N_CH     = 2,
  parameter  int PCM_W    = 16,
  parameter  int GAIN_W   = 8,
  parameter  int MAF_LOG2 = 3,
  parameter  int TOF_W    = 16,
  localparam int M        = PCM_W + GAIN_W,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic [N_CH*PCM_W-1:0]   pcm_i,
  input  logic [GAIN_W-1:0]       gain_i,
  input  logic [M-1:0]            thresh_i,
  input  logic [M-1:0]            hyst_i,
  input  logic                    start_i,
  input  logic [TOF_W-1:0]        blank_i,
  input  logic [TOF_W-1:0]        timeout_i,
  output logic [N_CH-1:0]         det_o,
  output logic                    hit_valid_o,
  output logic [CH_W-1:0]         hit_ch_o,
  output logic [TOF_W-1:0]        tof_o,
  output logic                    timeout_o,
  output logic                    busy_o
);

  localparam int D = 1 << MAF_LOG2;
  localparam int S = M + MAF_LOG2;

  typedef enum logic {IDLE, LISTEN} state_t;

  logic                v1_q, v2_q, v3_q;
  logic [MAF_LOG2-1:0] wp_q;
  logic [N_CH-1:0]     det_q;

  // All channels share one valid chain and one ring write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      wp_q <= '0;
    end else begin
      v1_q <= ce;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) wp_q <= wp_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [PCM_W-1:0]  pcm_ch;
    logic signed [M:0] pcm_ext;
    logic signed [M:0] gain_ext;
    logic signed [M:0] prod_q;
    logic [M-1:0]      mag_q;
    logic [M-1:0]      ring_q [D];
    logic [S-1:0]      sum_q;
    logic [M-1:0]      avg;
    logic [M-1:0]      clr_lvl;
    logic              det_r;

    assign pcm_ch   = pcm_i[g*PCM_W +: PCM_W];
    assign pcm_ext  = {{(M+1-PCM_W){pcm_ch[PCM_W-1]}}, pcm_ch};
    assign gain_ext = {{(M+1-GAIN_W){1'b0}}, gain_i};
    assign avg      = sum_q[S-1:MAF_LOG2];
    // Clear level saturates at zero so a wide hysteresis latches det.
    assign clr_lvl  = (hyst_i > thresh_i) ? '0 : thresh_i - hyst_i;
    assign det_q[g] = det_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '0;
        mag_q  <= '0;
        sum_q  <= '0;
        det_r  <= 1'b0;
        for (int i = 0; i < D; i++) ring_q[i] <= '0;
      end else begin
        if (ce) prod_q <= pcm_ext * gain_ext;
        mag_q <= M'(prod_q[M] ? -prod_q : prod_q);
        if (v2_q) begin
          sum_q        <= sum_q + S'(mag_q) - S'(ring_q[wp_q]);
          ring_q[wp_q] <= mag_q;
        end
        if (v3_q) begin
          if (avg >= thresh_i)    det_r <= 1'b1;
          else if (avg < clr_lvl) det_r <= 1'b0;
        end
      end
    end
  end

  assign det_o = det_q;

  state_t           state_q;
  logic [TOF_W-1:0] cnt_q;
  logic [CH_W-1:0]  low_ch;
  logic             hit;

  always_comb begin
    low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (det_q[i]) low_ch = CH_W'(i);
    end
  end

  assign hit = (|det_q) && (cnt_q >= blank_i);

  // Restart beats a hit, which beats a timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hit_valid_o <= 1'b0;
      hit_ch_o    <= '0;
      tof_o       <= '0;
      timeout_o   <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      hit_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LISTEN;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
        LISTEN: begin
          if (start_i) begin
            cnt_q <= '0;
          end else if (hit) begin
            hit_valid_o <= 1'b1;
            hit_ch_o    <= low_ch;
            tof_o       <= cnt_q;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
          end else if (ce && cnt_q == timeout_i) begin
            timeout_o <= 1'b1;
            tof_o     <= '1;
            busy_o    <= 1'b0;
            state_q   <= IDLE;
          end else if (ce) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_echo_detector.sv
// Randomised and directed bench for sonar_echo_detector against a
// sample-history reference model.
module tb_sonar_echo_detector;

  localparam int N_CH     = 2;
  localparam int PCM_W    = 16;
  localparam int GAIN_W   = 8;
  localparam int MAF_LOG2 = 3;
  localparam int TOF_W    = 16;
  localparam int M        = PCM_W + GAIN_W;
  localparam int D        = 1 << MAF_LOG2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  ce = 1'b0;
  logic [N_CH*PCM_W-1:0] pcm_i = '0;
  logic [GAIN_W-1:0]     gain_i = '0;
  logic [M-1:0]          thresh_i = '0;
  logic [M-1:0]          hyst_i = '0;
  logic                  start_i = 1'b0;
  logic [TOF_W-1:0]      blank_i = '0;
  logic [TOF_W-1:0]      timeout_i = '0;
  logic [N_CH-1:0]       det_o;
  logic                  hit_valid_o;
  logic [0:0]            hit_ch_o;
  logic [TOF_W-1:0]      tof_o;
  logic                  timeout_o;
  logic                  busy_o;

  always #5 clk = ~clk;

  sonar_echo_detector #(
    .N_CH(N_CH), .PCM_W(PCM_W), .GAIN_W(GAIN_W), .MAF_LOG2(MAF_LOG2), .TOF_W(TOF_W)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .pcm_i(pcm_i), .gain_i(gain_i),
    .thresh_i(thresh_i), .hyst_i(hyst_i), .start_i(start_i),
    .blank_i(blank_i), .timeout_i(timeout_i), .det_o(det_o),
    .hit_valid_o(hit_valid_o), .hit_ch_o(hit_ch_o), .tof_o(tof_o),
    .timeout_o(timeout_o), .busy_o(busy_o)
  );

  int num_checks = 0;
  int num_miscompares = 0;

  // Reference model: full sample history per channel, detections due 3 edges later.
  longint          mag_hist [N_CH][$];
  longint          avg_q    [N_CH][$];
  int              due_q[$];
  int              edge_n = 0;
  logic [N_CH-1:0] exp_det = '0;
  bit              exp_busy = 0, exp_hv = 0, exp_to = 0;
  int              exp_ch = 0, cnt_m = 0;
  longint          exp_tof = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    num_checks++;
    if (observed != expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s at edge %0d: observed %0d, expected %0d", tag, edge_n, observed, expected);
    end
  endtask

  task automatic model_update();
    longint p, m, s, a, clr;
    edge_n++;
    exp_hv = 0;
    exp_to = 0;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        mag_hist[c].delete();
        avg_q[c].delete();
      end
      due_q.delete();
      exp_det = '0; exp_busy = 0; exp_ch = 0; cnt_m = 0; exp_tof = 0;
      return;
    end
    if (!exp_busy) begin
      if (start_i) begin exp_busy = 1; cnt_m = 0; end
    end else if (start_i) begin
      cnt_m = 0;
    end else if (exp_det != 0 && cnt_m >= int'(blank_i)) begin
      exp_hv = 1;
      exp_tof = cnt_m;
      for (int c = N_CH - 1; c >= 0; c--) if (exp_det[c]) exp_ch = c;
      exp_busy = 0;
    end else if (ce && cnt_m == int'(timeout_i)) begin
      exp_to = 1;
      exp_tof = (longint'(1) << TOF_W) - 1;
      exp_busy = 0;
    end else if (ce) begin
      cnt_m = (cnt_m + 1) % (1 << TOF_W);
    end
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      clr = (hyst_i > thresh_i) ? 0 : longint'(thresh_i) - longint'(hyst_i);
      for (int c = 0; c < N_CH; c++) begin
        a = avg_q[c].pop_front();
        if (a >= longint'(thresh_i)) exp_det[c] = 1'b1;
        else if (a < clr)            exp_det[c] = 1'b0;
      end
    end
    if (ce) begin
      for (int c = 0; c < N_CH; c++) begin
        p = longint'($signed(pcm_i[c*PCM_W +: PCM_W]));
        m = p * longint'(gain_i);
        if (m < 0) m = -m;
        mag_hist[c].push_back(m);
        if (mag_hist[c].size() > D) void'(mag_hist[c].pop_front());
        s = 0;
        for (int i = 0; i < mag_hist[c].size(); i++) s += mag_hist[c][i];
        avg_q[c].push_back(s / D);
      end
      due_q.push_back(edge_n + 3);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit c, input bit s, input int p0, input int p1);
    rst = r;
    ce = c;
    start_i = s;
    pcm_i = {PCM_W'(p1), PCM_W'(p0)};
    @(posedge clk);
    #1;
    model_update();
    checkOutput("det", det_o, exp_det);
    checkOutput("busy", busy_o, exp_busy);
    checkOutput("hit_valid", hit_valid_o, exp_hv);
    checkOutput("timeout", timeout_o, exp_to);
    checkOutput("tof", tof_o, exp_tof);
    if (exp_hv) checkOutput("hit_ch", hit_ch_o, exp_ch);
  endtask

  task automatic feed(input int n, input int p0, input int p1);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, p0, p1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
  endtask

  // Runs a ping; p0/p1 apply from cycle 'from' on. Records first hit and timeout cycles.
  task automatic run_ping(input int ncyc, input int from, input int p0, input int p1,
                          input int restart_at, output int hit_cyc, output int hit_tof,
                          output int hit_chn, output int to_cyc);
    hit_cyc = -1; hit_tof = -1; hit_chn = -1; to_cyc = -1;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      applyStimulus(0, 1, (cyc == 0) || (cyc == restart_at),
                    (cyc >= from) ? p0 : 0, (cyc >= from) ? p1 : 0);
      if (hit_valid_o && hit_cyc < 0) begin
        hit_cyc = cyc; hit_tof = tof_o; hit_chn = hit_ch_o;
      end
      if (timeout_o && to_cyc < 0) to_cyc = cyc;
    end
  endtask

  initial begin
    int hc, ht, hch, tc;
    do_reset();
    checkOutput("reset_tof", tof_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_det", det_o, 0);

    // Step response: 7 samples -> avg 87, 8 -> 100, wrap keeps 100.
    gain_i = 1; thresh_i = 100; hyst_i = 0;
    feed(7, 100, 0);
    checkOutput("step_avg87", det_o, 2'b00);
    feed(1, 100, 0);
    checkOutput("step_avg100", det_o, 2'b01);
    feed(9, 100, 0);
    checkOutput("step_wrap", det_o, 2'b01);

    do_reset();
    gain_i = 255; thresh_i = 24'd8355840; hyst_i = 1;
    feed(16, -32768, 32767);
    checkOutput("extreme_det", det_o, 2'b01);

    do_reset();
    gain_i = 1; thresh_i = 1000; hyst_i = 200;
    feed(8, 1000, 0);
    checkOutput("hyst_set", det_o, 2'b01);
    feed(8, 850, 0);
    checkOutput("hyst_hold", det_o, 2'b01);
    feed(8, 799, 0);
    checkOutput("hyst_clear", det_o, 2'b00);

    do_reset();
    thresh_i = 100; hyst_i = 0; blank_i = 10; timeout_i = 500;
    run_ping(140, 120, 0, 1000, -1, hc, ht, hch, tc);
    checkOutput("echo_cycle", hc, 124);
    checkOutput("echo_tof", ht, 123);
    checkOutput("echo_ch", hch, 1);

    do_reset();
    run_ping(140, 120, 1000, 1000, -1, hc, ht, hch, tc);
    checkOutput("echo2_ch", hch, 0);
    checkOutput("echo2_tof", ht, 123);

    do_reset();
    run_ping(20, 1, 1000, 0, -1, hc, ht, hch, tc);
    checkOutput("blank_tof", ht, 10);
    checkOutput("blank_cycle", hc, 11);

    do_reset();
    run_ping(510, 0, 0, 0, -1, hc, ht, hch, tc);
    checkOutput("to_cycle", tc, 501);
    checkOutput("to_tof", tof_o, 16'hFFFF);
    checkOutput("to_nohit", hc, -1);

    do_reset();
    run_ping(820, 0, 0, 0, 300, hc, ht, hch, tc);
    checkOutput("restart_to_cycle", tc, 801);

    blank_i = 400;
    run_ping(20, 0, 1000, 0, -1, hc, ht, hch, tc);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_tof", tof_o, 0);
    checkOutput("rst_det", det_o, 0);

    // Random traffic; blank/timeout only change while idle.
    do_reset();
    gain_i = 2; thresh_i = 400; hyst_i = 100; blank_i = 5; timeout_i = 60;
    for (int i = 0; i < 2000; i++) begin
      if (!exp_busy && $urandom_range(0, 9) == 0) begin
        blank_i = TOF_W'($urandom_range(0, 15));
        timeout_i = TOF_W'($urandom_range(10, 80));
      end
      if ($urandom_range(0, 49) == 0) begin
        thresh_i = M'($urandom_range(200, 900));
        hyst_i = M'($urandom_range(0, 1000));
      end
      if ($urandom_range(0, 29) == 0) gain_i = GAIN_W'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 39) == 0,
                    int'($urandom_range(0, 800)) - 400, int'($urandom_range(0, 800)) - 400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_miscompares);
    $finish;
  end

endmodule
